// File: rtl/lbl_pkg.sv
// Shared types and sizes for the label SRAM arbiter of the connected-component labeling engine.
package lbl_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int IMG_W  = 32;
    localparam int NREQ   = 2;
    localparam int STAGES = 2;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_HOST = 1'b1
    } req_id_e;

    // One entry of the read-return pipe; only reads produce a response.
    typedef struct packed {
        logic    valid;
        req_id_e id;
        logic    is_read;
    } tag_t;

    function automatic logic tag_hit(input tag_t t, input req_id_e id);
        return t.valid && t.is_read && (t.id == id);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a lock owner for atomic bursts; grant is combinational.
module rr_arb2
    import lbl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] lock,
    output logic [NREQ-1:0] gnt
);

    logic    rr_q, rr_d;
    logic    own_vld_q, own_vld_d;
    req_id_e own_id_q, own_id_d;
    logic    hs;
    req_id_e hs_id;

    always_comb begin
        gnt = '0;
        if (own_vld_q) begin
            // Owner keeps the port even while idle; the other side just waits.
            gnt[own_id_q] = req[own_id_q];
        end else if (&req) begin
            gnt[rr_q] = 1'b1;
        end else begin
            gnt = req;
        end
    end

    assign hs    = |(req & gnt);
    assign hs_id = req_id_e'(gnt[1]);

    always_comb begin
        rr_d      = rr_q;
        own_vld_d = own_vld_q;
        own_id_d  = own_id_q;
        if (hs) begin
            if (lock[hs_id]) begin
                own_vld_d = 1'b1;
                own_id_d  = hs_id;
            end else begin
                own_vld_d = 1'b0;
                rr_d      = ~hs_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= 1'b0;
            own_vld_q <= 1'b0;
            own_id_q  <= REQ_CORE;
        end else begin
            rr_q      <= rr_d;
            own_vld_q <= own_vld_d;
            own_id_q  <= own_id_d;
        end
    end

endmodule

// File: rtl/lbl_sram_arb.sv
// Shares the single-port label SRAM between the labeling core and the readback pass;
// SRAM pins are registered and read data returns two cycles after the handshake.
module lbl_sram_arb
    import lbl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] sram_q,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    output logic              sram_wen
);

    logic [NREQ-1:0]   req, lock, gnt;
    logic              hs;
    req_id_e           sel;
    logic              we_sel;
    logic [ADDR_W-1:0] sram_a_q, sram_a_d;
    logic [DATA_W-1:0] sram_d_q, sram_d_d;
    logic              sram_wen_q, sram_wen_d;
    tag_t [STAGES-1:0] tag_q, tag_d;

    assign req  = {req1, req0};
    assign lock = {lock1, lock0};

    rr_arb2 u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .lock (lock),
        .gnt  (gnt)
    );

    assign gnt0   = gnt[0];
    assign gnt1   = gnt[1];
    assign hs     = |(req & gnt);
    assign sel    = req_id_e'(gnt[1]);
    assign we_sel = (sel == REQ_HOST) ? we1 : we0;

    always_comb begin
        sram_a_d   = sram_a_q;
        sram_d_d   = sram_d_q;
        sram_wen_d = 1'b1;
        if (hs) begin
            sram_a_d   = (sel == REQ_HOST) ? addr1 : addr0;
            sram_d_d   = (sel == REQ_HOST) ? wdata1 : wdata0;
            sram_wen_d = ~we_sel;
        end
    end

    // Stage 0 lines up with the SRAM address; stage 1 with sram_q.
    always_comb begin
        tag_d[0].valid   = hs;
        tag_d[0].id      = sel;
        tag_d[0].is_read = hs & ~we_sel;
        tag_d[1]         = tag_q[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_a_q   <= '0;
            sram_d_q   <= '0;
            sram_wen_q <= 1'b1;
            tag_q      <= '0;
        end else begin
            sram_a_q   <= sram_a_d;
            sram_d_q   <= sram_d_d;
            sram_wen_q <= sram_wen_d;
            tag_q      <= tag_d;
        end
    end

    assign sram_a   = sram_a_q;
    assign sram_d   = sram_d_q;
    assign sram_wen = sram_wen_q;

    assign rvalid0 = tag_hit(tag_q[STAGES-1], REQ_CORE);
    assign rvalid1 = tag_hit(tag_q[STAGES-1], REQ_HOST);
    assign rdata0  = rvalid0 ? sram_q : '0;
    assign rdata1  = rvalid1 ? sram_q : '0;

endmodule

// File: tb/tb_lbl_sram_arb.sv
// Directed vector bench for lbl_sram_arb with a behavioural 1024x8 SRAM model.
module tb_lbl_sram_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [9:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic [7:0] sram_q;
    logic [9:0] sram_a;
    logic [7:0] sram_d;
    logic       sram_wen;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lbl_sram_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .sram_q(sram_q), .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen)
    );

    // SRAM model: unwritten location a holds a[7:0] + 8'h25 (so mem[5] = 8'h2A).
    logic [7:0] mem [1024];
    logic       wr_vld [1024];
    always @(posedge clk) begin
        if (!sram_wen) begin
            mem[sram_a]    <= sram_d;
            wr_vld[sram_a] <= 1'b1;
        end
        sram_q <= (wr_vld[sram_a] === 1'b1) ? mem[sram_a] : sram_a[7:0] + 8'h25;
    end

    typedef struct {
        logic       r0, w0, l0;
        logic [9:0] a0;
        logic [7:0] d0;
        logic       r1, w1, l1;
        logic [9:0] a1;
        logic [7:0] d1;
        logic [1:0] eg;   // {gnt1, gnt0}
        logic [1:0] erv;  // {rvalid1, rvalid0}
        logic [7:0] erd0, erd1;
        logic [9:0] ea;
        logic       ewen;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(
        input logic r0, w0, l0, input logic [9:0] a0, input logic [7:0] d0,
        input logic r1, w1, l1, input logic [9:0] a1, input logic [7:0] d1,
        input logic [1:0] eg, input logic [1:0] erv, input logic [7:0] erd0, erd1,
        input logic [9:0] ea, input logic ewen);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.eg = eg; v.erv = erv; v.erd0 = erd0; v.erd1 = erd1; v.ea = ea; v.ewen = ewen;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        req0 = v.r0; we0 = v.w0; lock0 = v.l0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; lock1 = v.l1; addr1 = v.a1; wdata1 = v.d1;
    endtask

    task automatic idle();
        req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".sram_a"},   32'(sram_a),   32'h0);
        chk({tag, ".sram_d"},   32'(sram_d),   32'h0);
        chk({tag, ".sram_wen"}, 32'(sram_wen), 32'h1);
        chk({tag, ".rvalid"},   32'({rvalid1, rvalid0}), 32'h0);
        chk({tag, ".rdata0"},   32'(rdata0),   32'h0);
        chk({tag, ".rdata1"},   32'(rdata1),   32'h0);
    endtask

    initial begin
        // Each row: inputs for one cycle, and outputs expected during that cycle.
        //            r0 w0 l0 a0   d0     r1 w1 l1 a1   d1     gnt    rv     rd0    rd1    a     wen
        // contention from reset: grants alternate 0,1,0,1
        vecs.push_back(mk(0,0,0,  0,8'h00, 0,0,0,  0,8'h00, 2'b00, 2'b00, 8'h00, 8'h00,   0, 1));
        vecs.push_back(mk(1,0,0, 10,8'h00, 1,0,0, 20,8'h00, 2'b01, 2'b00, 8'h00, 8'h00,   0, 1));
        vecs.push_back(mk(1,0,0, 10,8'h00, 1,0,0, 20,8'h00, 2'b10, 2'b00, 8'h00, 8'h00,  10, 1));
        vecs.push_back(mk(1,0,0, 10,8'h00, 1,0,0, 20,8'h00, 2'b01, 2'b01, 8'h2F, 8'h00,  20, 1));
        vecs.push_back(mk(1,0,0, 10,8'h00, 1,0,0, 20,8'h00, 2'b10, 2'b10, 8'h00, 8'h39,  10, 1));
        vecs.push_back(mk(0,0,0,  0,8'h00, 0,0,0,  0,8'h00, 2'b00, 2'b01, 8'h2F, 8'h00,  20, 1));
        vecs.push_back(mk(0,0,0,  0,8'h00, 0,0,0,  0,8'h00, 2'b00, 2'b10, 8'h00, 8'h39,  20, 1));
        // single read of address 5
        vecs.push_back(mk(1,0,0,  5,8'h00, 0,0,0,  0,8'h00, 2'b01, 2'b00, 8'h00, 8'h00,  20, 1));
        vecs.push_back(mk(0,0,0,  0,8'h00, 0,0,0,  0,8'h00, 2'b00, 2'b00, 8'h00, 8'h00,   5, 1));
        vecs.push_back(mk(0,0,0,  0,8'h00, 0,0,0,  0,8'h00, 2'b00, 2'b01, 8'h2A, 8'h00,   5, 1));
        // locked RMW by requester 1 on address 100, requester 0 held reading 50
        vecs.push_back(mk(1,0,0, 50,8'h00, 1,0,1,100,8'h00, 2'b10, 2'b00, 8'h00, 8'h00,   5, 1));
        vecs.push_back(mk(1,0,0, 50,8'h00, 0,0,0,  0,8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 100, 1));
        vecs.push_back(mk(1,0,0, 50,8'h00, 1,1,0,100,8'h07, 2'b10, 2'b10, 8'h00, 8'h89, 100, 1));
        vecs.push_back(mk(1,0,0, 50,8'h00, 0,0,0,  0,8'h00, 2'b01, 2'b00, 8'h00, 8'h00, 100, 0));
        vecs.push_back(mk(0,0,0,  0,8'h00, 0,0,0,  0,8'h00, 2'b00, 2'b00, 8'h00, 8'h00,  50, 1));
        vecs.push_back(mk(0,0,0,  0,8'h00, 0,0,0,  0,8'h00, 2'b00, 2'b01, 8'h57, 8'h00,  50, 1));
        // write 1023 = FF, then read it back
        vecs.push_back(mk(1,1,0,1023,8'hFF,0,0,0,  0,8'h00, 2'b01, 2'b00, 8'h00, 8'h00,  50, 1));
        vecs.push_back(mk(1,0,0,1023,8'h00,0,0,0,  0,8'h00, 2'b01, 2'b00, 8'h00, 8'h00,1023, 0));
        vecs.push_back(mk(0,0,0,  0,8'h00, 0,0,0,  0,8'h00, 2'b00, 2'b00, 8'h00, 8'h00,1023, 1));
        vecs.push_back(mk(0,0,0,  0,8'h00, 0,0,0,  0,8'h00, 2'b00, 2'b01, 8'hFF, 8'h00,1023, 1));
        // requester 1 reads back the RMW result
        vecs.push_back(mk(0,0,0,  0,8'h00, 1,0,0,100,8'h00, 2'b10, 2'b00, 8'h00, 8'h00,1023, 1));
        vecs.push_back(mk(0,0,0,  0,8'h00, 0,0,0,  0,8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 100, 1));
        vecs.push_back(mk(0,0,0,  0,8'h00, 0,0,0,  0,8'h00, 2'b00, 2'b10, 8'h00, 8'h07, 100, 1));

        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        #1;
        chk({"reset.gnt"}, 32'({gnt1, gnt0}), 32'h0);
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d.gnt", i),      32'({gnt1, gnt0}),       32'(vecs[i].eg));
            chk($sformatf("v%0d.rvalid", i),   32'({rvalid1, rvalid0}), 32'(vecs[i].erv));
            if (vecs[i].erv[0]) chk($sformatf("v%0d.rdata0", i), 32'(rdata0), 32'(vecs[i].erd0));
            if (vecs[i].erv[1]) chk($sformatf("v%0d.rdata1", i), 32'(rdata1), 32'(vecs[i].erd1));
            chk($sformatf("v%0d.sram_a", i),   32'(sram_a),   32'(vecs[i].ea));
            chk($sformatf("v%0d.sram_wen", i), 32'(sram_wen), 32'(vecs[i].ewen));
        end

        // Reset in the cycle after a locked read handshake by requester 1.
        @(negedge clk);
        idle();
        req1 = 1; lock1 = 1; addr1 = 10'd5;
        #1;
        chk("rst_mid.gnt_before", 32'({gnt1, gnt0}), 32'h2);
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #1;
        chk_reset_state("rst_mid");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rst_mid.rvalid%0d", c), 32'({rvalid1, rvalid0}), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post_rst.rvalid%0d", c), 32'({rvalid1, rvalid0}), 32'h0);
        end
        // Lock must be gone and rr back at 0: contention goes to requester 0.
        @(negedge clk);
        req0 = 1; addr0 = 10'd3; req1 = 1; addr1 = 10'd4;
        #1;
        chk("post_rst.first_gnt", 32'({gnt1, gnt0}), 32'h1);
        @(negedge clk);
        idle();
        #1;
        chk("post_rst.sram_a", 32'(sram_a), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
